muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for `DATA_WIDTH`-bit operands. It is the sequential companion to the combinational ALU. It sits beside the ALU in the execute stage and uses a start/busy/done handshake so the control unit can stall while it works. Results and a `zero` flag are registered and held until the next accepted operation.

---
 rtl/muldiv_if.sv | 21 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Start/busy/done handshake bundle between the control unit and the
// iterative multiply/divide unit.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface muldiv_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) ();
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;

  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, sign fix-up, registered result and zero flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module muldiv_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
  } op_t;

  state_t         state, state_next;
  op_t            op_in, op_q;
  logic           neg_a_q, neg_b_q;
  logic [W-1:0]   opnd_q;      // multiplicand |a| or divisor |b|
  logic [2*W-1:0] prod_q;
  logic [W:0]     rem_q;
  logic [W-1:0]   quo_q;       // dividend shifts out as quotient shifts in
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   result_q;
  logic           zero_q;

  // Input decode for the start edge
  logic         signed_a, signed_b, in_neg_a, in_neg_b;
  logic [W-1:0] abs_a, abs_b;
  logic         div_by_zero, div_ovf, fast, accept;
  logic [W-1:0] fast_result;

  assign op_in    = op_t'(bus.op);
  assign signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
  assign signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign in_neg_a = signed_a & bus.a[W-1];
  assign in_neg_b = signed_b & bus.b[W-1];
  assign abs_a    = in_neg_a ? -bus.a : bus.a;
  assign abs_b    = in_neg_b ? -bus.b : bus.b;

  assign div_by_zero = bus.op[2] && (bus.b == '0);
  assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (bus.a == {1'b1, {(W-1){1'b0}}}) && (bus.b == '1);
  assign fast        = div_by_zero | div_ovf;
  assign accept      = bus.start && ((state == IDLE) || (state == DONE));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fast_result = '0;
    if (div_by_zero) fast_result = bus.op[1] ? bus.a : '1;
    else if (div_ovf) fast_result = bus.op[1] ? '0 : bus.a;
  end

  // One iteration step
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift, div_diff;
  logic         div_ge;

  assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
  assign div_shift = {rem_q[W-1:0], quo_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};

  // Sign correction and output select
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_result;

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
  assign rem_fix  = neg_a_q ? -rem_q[W-1:0] : rem_q[W-1:0];

  always_comb begin
    fix_result = rem_fix;
    case (op_q)
      OP_MUL:                        fix_result = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:               fix_result = quo_fix;
      default:                       fix_result = rem_fix;
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept)             state_next = fast ? DONE : CALC;
        else if (state == DONE) state_next = IDLE;
      end
      CALC:    if (cnt_q == CW'(W-1)) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so result/zero/counter have a
    // defined value on the very first cycle and after an aborted operation.
    if (rst) begin
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q    <= op_in;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            opnd_q  <= bus.op[2] ? abs_b : abs_a;
            prod_q  <= {{W{1'b0}}, abs_b};
            rem_q   <= '0;
            quo_q   <= abs_a;
            cnt_q   <= '0;
            if (fast) begin
              result_q <= fast_result;
              zero_q   <= (fast_result == '0);
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q[2]) begin
            rem_q <= div_ge ? div_diff : div_shift;
            quo_q <= {quo_q[W-2:0], div_ge};
          end else begin
            prod_q <= {mul_sum, prod_q[W-1:1]};
          end
        end
        FIX: begin
          result_q <= fix_result;
          zero_q   <= (fix_result == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == CALC) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (W=32): results, zero flag, latency,
// fast paths, ignored starts, back-to-back starts and async reset abort.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start for one cycle from a negedge, then scramble the inputs.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_1234;
  endtask

  // Called at the first negedge after the start edge (lat = 0 there).
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt,
                           output logic [W-1:0] res, output logic zb);
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      if (lat == poke_at) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    res = bus.result;
    zb  = bus.zero;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt,
                        output logic [W-1:0] res, output logic zb);
    @(negedge clk);
    issue(op, a, b);
    wait_done(-1, lat, busy_cnt, res, zb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    #12;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc; logic [W-1:0] res; logic zb;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_neg: got %h want ffffffeb", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done: got %b want 0", bus.busy); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu: got %h want fffffffe", res); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, res, zb);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL mulh: got %h want 00000000", res); end
    n_checks++; if (zb !== 1'b1) begin n_fail++; $display("FAIL mulh_zero: got %b want 1", zb); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu: got %h want ffffffff", res); end
  endtask

  task automatic test_div();
    int lat, bc; logic [W-1:0] res; logic zb;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg: got %h want fffffffd", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg: got %h want ffffffff", res); end
    run_op(3'b101, 32'd100, 32'd7, lat, bc, res, zb);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu: got %0d want 14", res); end
    run_op(3'b111, 32'd100, 32'd7, lat, bc, res, zb);
    n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu: got %0d want 2", res); end
    n_checks++; if (zb !== 1'b0) begin n_fail++; $display("FAIL remu_zero_clr: got %b want 0", zb); end
    run_op(3'b111, 32'd14, 32'd7, lat, bc, res, zb);
    n_checks++; if (res !== 32'd0) begin n_fail++; $display("FAIL remu_exact: got %0d want 0", res); end
    n_checks++; if (zb !== 1'b1) begin n_fail++; $display("FAIL remu_zero_set: got %b want 1", zb); end
  endtask

  task automatic test_fast_path();
    int lat, bc; logic [W-1:0] res; logic zb;
    run_op(3'b101, 32'd5, 32'd0, lat, bc, res, zb);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h want ffffffff", res); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL fast_latency: got %0d want 0", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL fast_busy_cycles: got %0d want 0", bc); end
    run_op(3'b110, 32'd5, 32'd0, lat, bc, res, zb);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL rem_by_zero: got %h want 00000005", res); end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, res, zb);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h want 80000000", res); end
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL div_overflow_latency: got %0d want 0", lat); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, res, zb);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rem_overflow: got %h want 00000000", res); end
    n_checks++; if (zb !== 1'b1) begin n_fail++; $display("FAIL rem_overflow_zero: got %b want 1", zb); end
  endtask

  task automatic test_ignore_start();
    int lat, bc; logic [W-1:0] res; logic zb;
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7);
    wait_done(5, lat, bc, res, zb);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignore_start_result: got %0d want 14", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [W-1:0] res; logic zb;
    run_op(3'b000, 32'd3, 32'd4, lat, bc, res, zb);
    n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL b2b_first: got %0d want 12", res); end
    issue(3'b111, 32'd100, 32'd7);   // started during the DONE cycle
    wait_done(-1, lat, bc, res, zb);
    n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL b2b_second: got %0d want 2", res); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", lat); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones; logic [W-1:0] res; logic zb;
    @(negedge clk);
    issue(3'b100, 32'hFFFF_FF9C, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h want 0", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL abort_zero: got %b want 1", bus.zero); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    run_op(3'b000, 32'd3, 32'd4, lat, bc, res, zb);
    n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL post_reset_mul: got %0d want 12", res); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
